r_clk_reader: RTL

- Read-side controller of the dual-clock FIFO; lives entirely in the read clock domain.
- Keeps the binary and Gray read pointers and synchronises the write-domain Gray pointer.
- Generates the registered empty flag, an occupancy estimate and an almost-empty flag.
- Drives a synchronous-read memory port, with a 2-entry output buffer giving first-word-fall-through valid/ready to the consumer.

---
 rtl/r_clk_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/r_clk_reader.sv
`default_nettype none
// ============================================================================
//  Module      : r_clk_reader
//  Description : Read-side controller of a dual-clock FIFO. Owns the binary
//                and Gray read pointers, synchronises the write Gray pointer,
//                produces registered empty / level / almost-empty flags and
//                fronts a synchronous-read memory with a 2-entry FWFT buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module r_clk_reader #(
    parameter int ADDRESS_SIZE    = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                    r_clk,
    input  logic                    rrst,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic                    r_empty,
    output logic                    r_almost_empty,
    output logic [ADDRESS_SIZE:0]   r_level
);

    localparam int                  c_PTR_W  = ADDRESS_SIZE + 1;
    localparam logic [c_PTR_W-1:0]  c_AE_TH  = c_PTR_W'(ALMOST_EMPTY_TH);

    // Output buffer occupancy states; entries are kept in arrival order.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } buf_state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]    r_bin;
    logic [c_PTR_W-1:0]    r_wq1;
    logic [c_PTR_W-1:0]    r_wq2;
    buf_state_t            r_state;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  w_pop;
    logic                  w_land;
    logic [1:0]            w_buf_cnt;
    logic [1:0]            w_occ;
    logic [1:0]            w_occ_after_pop;
    logic                  w_rd_en;
    logic [c_PTR_W-1:0]    w_bnext;
    logic [c_PTR_W-1:0]    w_gnext;
    logic [c_PTR_W-1:0]    w_wbin;
    logic [c_PTR_W-1:0]    w_level_next;
    buf_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [DATA_WIDTH-1:0] w_tail_next;

    // Gray to binary conversion: each binary bit is the XOR of all Gray
    // bits at or above it.
    function automatic logic [c_PTR_W-1:0] gray2bin(input logic [c_PTR_W-1:0] g);
        logic [c_PTR_W-1:0] b;
        b = g;
        for (int i = c_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Consumer handshake and memory landing
    // ------------------------------------------------------------------
    assign r_valid = (r_state != S_EMPTY);
    assign r_data  = r_head;
    assign w_pop   = r_valid & r_ready;
    assign w_land  = r_inflight;

    // Occupancy (buffered + in flight) decides whether another read fits.
    always_comb begin
        w_buf_cnt = 2'd0;
        case (r_state)
            S_EMPTY: w_buf_cnt = 2'd0;
            S_ONE:   w_buf_cnt = 2'd1;
            S_TWO:   w_buf_cnt = 2'd2;
            default: w_buf_cnt = 2'd0;
        endcase
        w_occ           = w_buf_cnt + {1'b0, r_inflight};
        w_occ_after_pop = w_occ - {1'b0, w_pop};
        w_rd_en         = !rrst && !r_empty && (w_occ_after_pop < 2'd2);
    end

    assign mem_rd_en = w_rd_en;
    assign r_addr    = r_bin[ADDRESS_SIZE-1:0];

    // Next read pointer, its Gray form, and the level seen against the
    // synchronised write pointer.
    always_comb begin
        w_bnext      = r_bin + {{ADDRESS_SIZE{1'b0}}, w_rd_en};
        w_gnext      = w_bnext ^ (w_bnext >> 1);
        w_wbin       = gray2bin(r_wq2);
        w_level_next = w_wbin - w_bnext;
    end

    // Write-pointer synchroniser, read pointers and status flags.
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_wq1          <= '0;
            r_wq2          <= '0;
            r_bin          <= '0;
            r_ptr          <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
        end else begin
            r_wq1          <= w_ptr;
            r_wq2          <= r_wq1;
            r_bin          <= w_bnext;
            r_ptr          <= w_gnext;
            r_empty        <= (w_gnext == r_wq2);
            r_almost_empty <= (w_level_next <= c_AE_TH);
            r_level        <= w_level_next;
        end
    end

    // Output buffer state, entries and in-flight flag.
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_state    <= S_EMPTY;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
        end
    end

    // Buffer next state: a landing word goes behind any held entry, a pop
    // shifts the tail into the head. A pop while empty has no effect.
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        case (r_state)
            S_EMPTY: begin
                if (w_land) begin
                    w_head_next  = mem_rd_data;
                    w_state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (w_land && w_pop) begin
                    w_head_next = mem_rd_data;
                end else if (w_land) begin
                    w_tail_next  = mem_rd_data;
                    w_state_next = S_TWO;
                end else if (w_pop) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                // A landing word without a pop cannot occur here: the read
                // enable is withheld whenever two entries are committed.
                if (w_pop) begin
                    w_head_next = r_tail;
                    if (w_land) begin
                        w_tail_next = mem_rd_data;
                    end else begin
                        w_state_next = S_ONE;
                    end
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

endmodule
`default_nettype wire
